alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, clocked successor to the 32-bit combinational ALU: WIDTH-bit operands, 8 operations, full flag set, valid/ready handshakes on input and output.
- Single-cycle ops return a result one cycle after acceptance. MUL is a multi-cycle iterative shift-add.
- Sits between the operand-issue logic and the writeback register, and absorbs writeback backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block accepts when in_valid & in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount = b[SHW-1:0])
- cin  in  1  carry/borrow-in (ADD/SUB only)
- op  in  3  ADD=0 SUB=1 OR=2 AND=3 XOR=4 SLL=5 SRL=6 MUL=7
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result when out_valid & out_ready
- result  out  WIDTH  result
- carry  out  1  ADD: carry-out; SUB: borrow; MUL: high half nonzero; else 0
- overflow  out  1  signed overflow for ADD/SUB; else 0
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset: state=IDLE; in_ready=0 while rst_n low, then 1; out_valid=0; result=0; carry, overflow, zero, negative=0; MUL counter and accumulator cleared.
- States: IDLE (empty), BUSY (MUL iterating), HOLD (result valid, not yet taken).
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational from out_ready, so a new op can be accepted in the same cycle the held result leaves. It is 0 throughout BUSY.
- Accept, non-MUL: result and flags registered at the next edge → HOLD. Latency 1 cycle.
- Accept, MUL:
  - Latch a and b. Clear the 2*WIDTH accumulator and counter → BUSY.
  - Each cycle: if multiplier bit set, add the shifted multiplicand; shift; count.
  - After exactly WIDTH BUSY cycles → HOLD with result = low WIDTH bits of a*b (unsigned) and carry = |high WIDTH bits.
  - Latency is WIDTH+1 edges from acceptance to out_valid.
- HOLD with out_ready=0: result and flags stay stable; in_ready=0.
- HOLD with out_ready=1 and no new accept → IDLE, out_valid=0 next cycle.
- Simultaneous drain and accept in HOLD: output drains, the new op is accepted, and the next state is HOLD (non-MUL) or BUSY (MUL). No bubble for single-cycle ops.
- ADD: {carry,result} = a + b + cin in WIDTH+1 bits. overflow = (a[msb]==b[msb]) & (result[msb]!=a[msb]).
- SUB: result = a - b - cin (mod 2^WIDTH). carry (borrow) = (a < b + cin), computed in WIDTH+1 bits. overflow = (a[msb]!=b[msb]) & (result[msb]!=a[msb]).
- SLL/SRL: logical shift by b[SHW-1:0]; upper bits of b ignored. Shift by 0 passes a through.
- zero and negative are computed from the final result for every op, including MUL.
- Inputs are ignored when not accepted. Reset asserted mid-MUL or mid-HOLD aborts immediately, and the result is discarded.

Decomposition:
- Package alu_pipe_pkg: op_e enum (ADD..MUL, 3 bits), state_e enum (IDLE, BUSY, HOLD), flags_t struct {carry, overflow, zero, negative}.
- One natural sub-module: alu_mul_iter. It is the WIDTH-cycle shift-add multiplier with a start/done interface and a 2*WIDTH product output.
- Single-cycle ops stay inline in alu_pipe.

Test Plan (WIDTH=32):
- ADD a=FFFFFFFF b=00000001 cin=0, out_ready=1 → next cycle: result=0, carry=1, zero=1, overflow=0; in_ready stays 1.
- ADD a=7FFFFFFF b=1 cin=0 → result=80000000, overflow=1, negative=1, carry=0. SUB a=5 b=7 cin=0 → result=FFFFFFFE, carry=1, negative=1.
- MUL a=00010000 b=00010000 → in_ready=0 for 32 cycles; out_valid on the 33rd edge with result=0, carry=1, zero=1. MUL 3*5 → result=F, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after an OR result → result stable and in_ready=0 throughout. Raise out_ready with in_valid=1 (XOR F0F0,FFFF) → next cycle new result=0F0F with no bubble.
- SLL a=1 b=0000_0025 (amount 5) → result=20; SRL a=80000000 b=31 → result=1.
- Drop rst_n for 1 cycle mid-MUL (cycle 10) → out_valid=0, state IDLE. A subsequent ADD 2+2 returns 4 with correct latency.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode, FSM state and flag types for alu_pipe
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_OR  = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: WIDTH-cycle iterative unsigned shift-add multiplier
// Ports: clk, rst_n (async active-low), start (latch a/b and begin),
//        a, b (operands), done (high during the final iteration cycle),
//        product (2*WIDTH-bit result, valid while done is high)
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               busy;

    // product includes the current iteration's partial sum, so the
    // owner can capture the full result on the same edge done is seen
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy & (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            busy   <= ~done;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: clocked WIDTH-bit ALU with valid/ready handshakes and iterative MUL
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready, a, b, cin, op : operand issue handshake
//        out_valid/out_ready, result      : writeback handshake
//        carry, overflow, zero, negative  : flags registered with result
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              carry,
    output logic              overflow,
    output logic              zero,
    output logic              negative
);

    import alu_pipe_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    state_e             state, state_n;
    flags_t             flags, flags_n;
    op_e                opc;
    logic [WIDTH-1:0]   res_n, alu_r;
    logic               alu_c, alu_v;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic               mul_done, accept, is_mul, load;

    assign opc      = op_e'(op);
    assign is_mul   = opc == OP_MUL;
    // ready follows out_ready combinationally so HOLD can drain and refill in one cycle
    assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

    // borrow of a - b - cin appears as bit WIDTH of the extended difference
    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept & is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (prod)
    );

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (opc)
            OP_ADD: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   alu_r = a | b;
            OP_AND:  alu_r = a & b;
            OP_XOR:  alu_r = a ^ b;
            OP_SLL:  alu_r = a << b[SHW-1:0];
            OP_SRL:  alu_r = a >> b[SHW-1:0];
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        res_n            = (state == BUSY) ? prod[WIDTH-1:0] : alu_r;
        flags_n.carry    = (state == BUSY) ? |prod[2*WIDTH-1:WIDTH] : alu_c;
        flags_n.overflow = (state == BUSY) ? 1'b0 : alu_v;
        flags_n.zero     = res_n == '0;
        flags_n.negative = res_n[WIDTH-1];
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n = is_mul ? BUSY : HOLD;
                load    = ~is_mul;
            end
            BUSY: if (mul_done) begin
                state_n = HOLD;
                load    = 1'b1;
            end
            HOLD: if (out_ready) begin
                state_n = accept ? (is_mul ? BUSY : HOLD) : IDLE;
                load    = accept & ~is_mul;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                result <= res_n;
                flags  <= flags_n;
            end
        end
    end

    assign out_valid = state == HOLD;
    assign carry     = flags.carry;
    assign overflow  = flags.overflow;
    assign zero      = flags.zero;
    assign negative  = flags.negative;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe at WIDTH=32
module tb_alu_pipe;

    import alu_pipe_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, carry, overflow, zero, negative;
    logic [31:0] result;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_x;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    function automatic exp_t e(input logic [31:0] r, input logic c, input logic v,
                               input logic z, input logic n);
        return {r, c, v, z, n};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // present one op and hold it until accepted; expectation is queued at acceptance
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input exp_t ex, input bit push);
        int n = 0;
        op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d", o);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back(ex);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // count edges from acceptance (edge 1) until out_valid, watching in_ready
    task automatic mul_wait(output int n, output bit bad);
        n = 1;
        bad = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) bad = 1'b1;
            @(posedge clk);
            #1 n++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h with no expectation", result);
            end else begin
                mon_x = q.pop_front();
                if ({result, carry, overflow, zero, negative} !== mon_x) begin
                    errors++;
                    $display("FAIL result: got r=%h c=%b v=%b z=%b n=%b want r=%h c=%b v=%b z=%b n=%b",
                             result, carry, overflow, zero, negative,
                             mon_x.r, mon_x.c, mon_x.v, mon_x.z, mon_x.n);
                end
            end
        end
    end

    initial begin
        int  n;
        bit  bad;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {28'b0, carry, overflow, zero, negative}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, e(32'h0, 1, 0, 1, 0), 1);
        chk("add_latency", {31'b0, out_valid}, 32'd1);
        chk("add_in_ready", {31'b0, in_ready}, 32'd1);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, e(32'h8000_0000, 0, 1, 0, 1), 1);
        issue(OP_SUB, 32'h5, 32'h7, 1'b0, e(32'hFFFF_FFFE, 1, 0, 0, 1), 1);
        issue(OP_ADD, 32'h1, 32'h1, 1'b1, e(32'h3, 0, 0, 0, 0), 1);
        issue(OP_SUB, 32'h0, 32'h0, 1'b1, e(32'hFFFF_FFFF, 1, 0, 0, 1), 1);
        issue(OP_SUB, 32'h8000_0000, 32'h1, 1'b0, e(32'h7FFF_FFFF, 0, 1, 0, 0), 1);

        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, e(32'h0, 1, 0, 1, 0), 1);
        mul_wait(n, bad);
        chk("mul_latency", n, 32'd33);
        chk("mul_busy_in_ready", {31'b0, bad}, 32'd0);
        issue(OP_MUL, 32'h3, 32'h5, 1'b0, e(32'hF, 0, 0, 0, 0), 1);
        mul_wait(n, bad);
        chk("mul2_latency", n, 32'd33);
        chk("mul2_busy_in_ready", {31'b0, bad}, 32'd0);

        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(OP_OR, 32'h0F00, 32'h00F0, 1'b0, e(32'h0FF0, 0, 0, 0, 0), 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("hold_result", result, 32'h0FF0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
        issue(OP_XOR, 32'hF0F0, 32'hFFFF, 1'b0, e(32'h0F0F, 0, 0, 0, 0), 1);
        chk("xor_no_bubble_valid", {31'b0, out_valid}, 32'd1);
        chk("xor_no_bubble_result", result, 32'h0F0F);

        issue(OP_SLL, 32'h1, 32'h25, 1'b0, e(32'h20, 0, 0, 0, 0), 1);
        issue(OP_SRL, 32'h8000_0000, 32'd31, 1'b0, e(32'h1, 0, 0, 0, 0), 1);
        issue(OP_SLL, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b0, e(32'hDEAD_BEEF, 0, 0, 0, 1), 1);
        issue(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, e(32'h0F00_0F00, 0, 0, 0, 0), 1);
        issue(OP_OR, 32'h0, 32'h0, 1'b1, e(32'h0, 0, 0, 1, 0), 1);

        issue(OP_MUL, 32'h1234, 32'h5678, 1'b0, e(32'h0, 0, 0, 0, 0), 0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_idle_ready", {31'b0, in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_result", {31'b0, out_valid}, 32'd0);
        issue(OP_ADD, 32'h2, 32'h2, 1'b0, e(32'h4, 0, 0, 0, 0), 1);
        chk("post_abort_latency", {31'b0, out_valid}, 32'd1);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
